// File: rtl/scroller_pkg.sv
// -----------------------------------------------------------------------------
// scroller_pkg
// Shared types and constants for the lane scroller (river logs / traffic).
//   coord_t : 10-bit unsigned screen x coordinate
//   vel_t   : signed 2-bit per-lane velocity (+1, -1, 0)
//   X_LEFT_DEF / X_RIGHT_DEF : default playfield window edges
//   DIR_LEFT / DIR_RIGHT     : encoding of the per-lane direction input
//   init_x()                 : start position of object j in a lane
// -----------------------------------------------------------------------------
package scroller_pkg;

  typedef logic [9:0]        coord_t;
  typedef logic signed [1:0] vel_t;

  localparam coord_t X_LEFT_DEF  = 10'd96;
  localparam coord_t X_RIGHT_DEF = 10'd544;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam vel_t VEL_NONE  = 2'sb00;
  localparam vel_t VEL_RIGHT = 2'sb01;
  localparam vel_t VEL_LEFT  = 2'sb11;

  // Initial layout: x_left + j*spacing, truncated to the 10-bit coordinate.
  function automatic coord_t init_x(input coord_t x_left, input int unsigned j,
                                    input coord_t spacing);
    logic [31:0] prod;
    prod = j * {22'd0, spacing};
    return x_left + prod[9:0];
  endfunction

endpackage

// File: rtl/lane_scroller_lane.sv
// -----------------------------------------------------------------------------
// lane_scroller_lane
// One scrolling lane: step-divider counter, OBJS_PER_LANE x position registers
// with wrap-around, and registered step / velocity outputs.
//
// Build option: LANE_SPEEDUP_EN -- when defined, the step period is
// div >> speed_shift (clamped to 1 if div is nonzero); otherwise speed_shift
// is ignored and the period is div.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   run               1 = advance, 0 = pause (counter/positions hold)
//   restart           reload initial layout and clear counter
//   dir               1 = move right (+x), 0 = move left (-x)
//   div               step period in clocks, 0 = lane frozen
//   len               object length in pixels (sets the wrap points)
//   spacing           start spacing between consecutive objects
//   speed_shift       divider right-shift (speed-up build only)
//   obj_x             packed object x, object j at [j*10 +: 10]
//   step              1-cycle pulse in the cycle obj_x shows the new value
//   vel               signed velocity matching step (+1 / -1 / 0)
// -----------------------------------------------------------------------------
module lane_scroller_lane
  import scroller_pkg::*;
#(
  parameter int     OBJS_PER_LANE = 3,
  parameter int     DIV_W         = 24,
  parameter coord_t X_LEFT        = X_LEFT_DEF,
  parameter coord_t X_RIGHT       = X_RIGHT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      restart,
  input  logic                      dir,
  input  logic [DIV_W-1:0]          div,
  input  logic [9:0]                len,
  input  logic [9:0]                spacing,
  input  logic [1:0]                speed_shift,
  output logic [OBJS_PER_LANE*10-1:0] obj_x,
  output logic                      step,
  output logic [1:0]                vel
);

  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  vel_t             vel_q, vel_d;
  coord_t           wrap_lo;

`ifdef LANE_SPEEDUP_EN
  logic [DIV_W-1:0] shifted;
  assign shifted = div >> speed_shift;
  // A nonzero divider never collapses to "frozen" through speed-up.
  assign eff_div = (shifted == '0 && div != '0) ? DIV_W'(1) : shifted;
`else
  logic unused_speed_shift;
  assign unused_speed_shift = ^speed_shift;
  assign eff_div = div;
`endif

  // Left-moving objects re-enter from X_RIGHT once fully off the left edge;
  // right-moving objects re-enter at this point, just off the left edge.
  assign wrap_lo = X_LEFT - len;

  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    vel_d  = VEL_NONE;
    if (restart) begin
      cnt_d = '0;
    end else if (run && eff_div != '0) begin
      // >= so that a divider lowered below the running count steps at once.
      if (cnt_q >= eff_div - 1'b1) begin
        cnt_d  = '0;
        step_d = 1'b1;
        vel_d  = (dir == DIR_RIGHT) ? VEL_RIGHT : VEL_LEFT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
      vel_q  <= VEL_NONE;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
      vel_q  <= vel_d;
    end
  end

  generate
    for (genvar gi = 0; gi < OBJS_PER_LANE; gi++) begin : g_obj
      coord_t x_q, x_d, x_init;

      assign x_init = init_x(X_LEFT, gi, spacing);

      always_comb begin
        x_d = x_q;
        if (restart) begin
          x_d = x_init;
        end else if (step_d) begin
          if (dir == DIR_RIGHT) begin
            x_d = (x_q >= X_RIGHT) ? wrap_lo : x_q + 1'b1;
          end else begin
            x_d = (x_q <= wrap_lo) ? X_RIGHT : x_q - 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) x_q <= x_init;
        else       x_q <= x_d;
      end

      assign obj_x[gi*10 +: 10] = x_q;
    end
  endgenerate

  assign step = step_q;
  assign vel  = vel_q;

endmodule

// File: rtl/lane_scroller.sv
// -----------------------------------------------------------------------------
// lane_scroller
// NUM_LANES independent horizontal scrolling lanes, each with OBJS_PER_LANE
// objects moving across the window [X_LEFT, X_RIGHT]. Direction, step period,
// object length and spacing are runtime inputs per lane.
//
// Build option: LANE_SPEEDUP_EN -- enables divider right-shift by speed_shift.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   run            1 = lanes advance, 0 = pause
//   restart        synchronous reload of the initial layout
//   lane_dir       per lane: 1 = right, 0 = left
//   lane_div       per lane step period (DIV_W bits each), 0 = frozen
//   lane_len       per lane object length (10 bits each)
//   lane_spacing   per lane start spacing (10 bits each)
//   speed_shift    divider right-shift (speed-up build only)
//   obj_x          lane l object j at [(l*OBJS_PER_LANE+j)*10 +: 10]
//   lane_step      per lane 1-cycle step pulse
//   lane_vel       per lane signed 2-bit velocity at [l*2 +: 2]
// -----------------------------------------------------------------------------
module lane_scroller
  import scroller_pkg::*;
#(
  parameter int     NUM_LANES     = 6,
  parameter int     OBJS_PER_LANE = 3,
  parameter coord_t X_LEFT        = X_LEFT_DEF,
  parameter coord_t X_RIGHT       = X_RIGHT_DEF,
  parameter int     DIV_W         = 24
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  run,
  input  logic                                  restart,
  input  logic [NUM_LANES-1:0]                  lane_dir,
  input  logic [NUM_LANES*DIV_W-1:0]            lane_div,
  input  logic [NUM_LANES*10-1:0]               lane_len,
  input  logic [NUM_LANES*10-1:0]               lane_spacing,
  input  logic [1:0]                            speed_shift,
  output logic [NUM_LANES*OBJS_PER_LANE*10-1:0] obj_x,
  output logic [NUM_LANES-1:0]                  lane_step,
  output logic [NUM_LANES*2-1:0]                lane_vel
);

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_scroller_lane #(
        .OBJS_PER_LANE (OBJS_PER_LANE),
        .DIV_W         (DIV_W),
        .X_LEFT        (X_LEFT),
        .X_RIGHT       (X_RIGHT)
      ) u_lane (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .restart     (restart),
        .dir         (lane_dir[gi]),
        .div         (lane_div[gi*DIV_W +: DIV_W]),
        .len         (lane_len[gi*10 +: 10]),
        .spacing     (lane_spacing[gi*10 +: 10]),
        .speed_shift (speed_shift),
        .obj_x       (obj_x[gi*OBJS_PER_LANE*10 +: OBJS_PER_LANE*10]),
        .step        (lane_step[gi]),
        .vel         (lane_vel[gi*2 +: 2])
      );
    end
  endgenerate

endmodule
